header_stripper: RTL

- Receive-side counterpart of the frame header insertion stage.
- Consumes one merged AXI-Stream frame: data beats, then metadata beats, then one frame-counter beat.
- Splits the frame into a data output stream and a metadata output stream, and captures the frame counter.
- Checks frame-counter continuity and reports frame and error statistics. Sits ahead of the host DMA / consumer logic.

---
 rtl/header_pkg.sv | 23 ++
 rtl/header_stripper_seq_checker.sv | 41 ++++
 rtl/header_stripper.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/header_pkg.sv
// Shared definitions for the frame header insertion/stripping stages.
// Holds the stream state encoding and default widths.
package header_pkg;

  // Position within a merged frame: payload, metadata, frame-counter beat.
  typedef enum logic [1:0] {
    DATA  = 2'd0,
    META  = 2'd1,
    COUNT = 2'd2
  } hdr_state_e;

  localparam int unsigned HDR_DW    = 128;
  localparam int unsigned HDR_CNT_W = 64;

  // Index of the last data beat in a frame; a zero packet size degrades
  // to a single data beat.
  function automatic logic [31:0] last_data_idx(input logic [31:0] frame_size,
                                                input logic [15:0] packet_size);
    if (packet_size == '0) return '0;
    return frame_size / {16'd0, packet_size};
  endfunction

endpackage

// File: rtl/header_stripper_seq_checker.sv
// Frame-counter continuity checker.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   cnt_fire_i      - a frame-counter beat was accepted this cycle
//   cnt_i           - frame-counter value carried by that beat
//   seq_error_o     - sticky: a counter did not follow its predecessor by +1
module seq_checker
  import header_pkg::*;
#(
  parameter int unsigned CNT_W = HDR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_fire_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             seq_error_o
);

  logic             first_frame_q;
  logic [CNT_W-1:0] prev_q;
  logic             seq_error_q;
  logic [CNT_W-1:0] prev_inc;

  // Wraps naturally from all-ones to zero.
  assign prev_inc = prev_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      first_frame_q <= 1'b1;
      prev_q        <= '0;
      seq_error_q   <= 1'b0;
    end else if (cnt_fire_i) begin
      if (!first_frame_q && (cnt_i != prev_inc)) seq_error_q <= 1'b1;
      prev_q        <= cnt_i;
      first_frame_q <= 1'b0;
    end
  end

  assign seq_error_o = seq_error_q;

endmodule

// File: rtl/header_stripper.sv
// Splits a merged frame (data beats, metadata beats, one counter beat) into
// a payload stream and a metadata stream, captures the frame counter and
// keeps frame/error statistics.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   FRAME_SIZE, PACKET_SIZE     - frame geometry, sampled at data beat 0
//   axis_in_*                   - merged input stream
//   axis_data_*                 - payload output stream (tlast on last beat)
//   axis_meta_*                 - metadata output stream (tlast on last beat)
//   frame_counter(_valid)       - last captured counter, one-cycle update pulse
//   frames_received             - completed frames, wraps
//   seq_error, cfg_error        - sticky error flags
//   fsm_state                   - current state for debug
module header_stripper
  import header_pkg::*;
#(
  parameter int unsigned DW               = HDR_DW,
  parameter int unsigned META_DATA_LENGTH = 1,
  parameter int unsigned CNT_W            = HDR_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      FRAME_SIZE,
  input  logic [15:0]      PACKET_SIZE,
  input  logic [DW-1:0]    axis_in_tdata,
  input  logic             axis_in_tvalid,
  output logic             axis_in_tready,
  output logic [DW-1:0]    axis_data_tdata,
  output logic             axis_data_tvalid,
  input  logic             axis_data_tready,
  output logic             axis_data_tlast,
  output logic [DW-1:0]    axis_meta_tdata,
  output logic             axis_meta_tvalid,
  input  logic             axis_meta_tready,
  output logic             axis_meta_tlast,
  output logic [CNT_W-1:0] frame_counter,
  output logic             frame_counter_valid,
  output logic [31:0]      frames_received,
  output logic             seq_error,
  output logic             cfg_error,
  output logic [1:0]       fsm_state
);

  hdr_state_e       state_q;
  logic [31:0]      beat_q;
  logic [31:0]      n_q;
  logic [CNT_W-1:0] frame_counter_q;
  logic             frame_counter_valid_q;
  logic [31:0]      frames_received_q;
  logic             cfg_error_q;

  logic [31:0]      n_now;
  logic [31:0]      n_eff;
  logic             in_fire;
  logic             data_last;
  logic             meta_last;

  // At data beat 0 the geometry is taken straight from the inputs so that
  // tlast and the DATA->META decision are correct on the very first beat.
  assign n_now     = last_data_idx(FRAME_SIZE, PACKET_SIZE);
  assign n_eff     = (beat_q == '0) ? n_now : n_q;
  assign data_last = (beat_q == n_eff);
  assign meta_last = (beat_q == META_DATA_LENGTH);
  assign in_fire   = axis_in_tvalid && axis_in_tready;

  always_comb begin
    axis_in_tready   = 1'b0;
    axis_data_tvalid = 1'b0;
    axis_data_tdata  = '0;
    axis_data_tlast  = 1'b0;
    axis_meta_tvalid = 1'b0;
    axis_meta_tdata  = '0;
    axis_meta_tlast  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        DATA: begin
          axis_in_tready   = axis_data_tready;
          axis_data_tvalid = axis_in_tvalid;
          axis_data_tdata  = axis_in_tdata;
          axis_data_tlast  = data_last;
        end
        META: begin
          axis_in_tready   = axis_meta_tready;
          axis_meta_tvalid = axis_in_tvalid;
          axis_meta_tdata  = axis_in_tdata;
          axis_meta_tlast  = meta_last;
        end
        COUNT:   axis_in_tready = 1'b1;
        default: axis_in_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= DATA;
      beat_q                <= '0;
      n_q                   <= '0;
      frame_counter_q       <= '0;
      frame_counter_valid_q <= 1'b0;
      frames_received_q     <= '0;
      cfg_error_q           <= 1'b0;
    end else begin
      frame_counter_valid_q <= 1'b0;
      if (in_fire) begin
        unique case (state_q)
          DATA: begin
            if (beat_q == '0) begin
              n_q <= n_now;
              if (PACKET_SIZE == '0) cfg_error_q <= 1'b1;
            end
            if (data_last) begin
              state_q <= META;
              beat_q  <= '0;
            end else begin
              beat_q  <= beat_q + 32'd1;
            end
          end
          META: begin
            if (meta_last) begin
              state_q <= COUNT;
              beat_q  <= '0;
            end else begin
              beat_q  <= beat_q + 32'd1;
            end
          end
          COUNT: begin
            state_q               <= DATA;
            beat_q                <= '0;
            frame_counter_q       <= axis_in_tdata[CNT_W-1:0];
            frame_counter_valid_q <= 1'b1;
            frames_received_q     <= frames_received_q + 32'd1;
          end
          default: begin
            state_q <= DATA;
            beat_q  <= '0;
          end
        endcase
      end
    end
  end

  seq_checker #(
    .CNT_W(CNT_W)
  ) u_seq_checker (
    .clk        (clk),
    .reset      (reset),
    .cnt_fire_i (in_fire && (state_q == COUNT)),
    .cnt_i      (axis_in_tdata[CNT_W-1:0]),
    .seq_error_o(seq_error)
  );

  assign frame_counter       = frame_counter_q;
  assign frame_counter_valid = frame_counter_valid_q;
  assign frames_received     = frames_received_q;
  assign cfg_error           = cfg_error_q;
  assign fsm_state           = state_q;

endmodule
